stream_demux: RTL

Parametrised, registered 1-to-NCH stream demultiplexer with valid/ready handshaking, per-channel single-entry output buffers and a broadcast mode. It replaces the fixed 1-bit, 4-way combinational demux wherever a data word must be steered to one of several downstream consumers that can stall independently. It sits between a single producer stream and NCH consumer streams. Every output is registered, so no combinational path runs from input data to output data.

---
 rtl/stream_demux.sv | 83 ++++++++
 1 files changed

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NCH stream demultiplexer with valid/ready
// handshaking, one single-entry buffer per output channel, a broadcast mode
// and a saturating counter of words dropped for an out-of-range select.
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_bcast,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [7:0]           drop_cnt
);

    // Channel i occupies out_data[i*WIDTH +: WIDTH]; the packed layout matches.
    logic [NCH-1:0][WIDTH-1:0] data_q;
    logic [NCH-1:0]            free;
    logic [NCH-1:0]            load;
    logic                      sel_ok;
    logic                      xfer;
    logic                      drop;

    // A full buffer that is draining this cycle can accept a new word.
    assign free     = ~out_valid | out_ready;
    assign sel_ok   = int'(in_sel) < NCH;
    assign xfer     = in_valid && in_ready;
    assign drop     = xfer && !in_bcast && !sel_ok;
    assign out_data = data_q;

    // in_ready depends only on channel occupancy and routing, never on in_valid.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = free[in_sel];
        end
    end

    // Decode which buffers capture the incoming word; broadcast is all-or-none.
    always_comb begin
        load = '0;
        if (xfer) begin
            if (in_bcast) begin
                load = '1;
            end else if (sel_ok) begin
                load[in_sel] = 1'b1;
            end
        end
    end

    // Buffer valid/data registers and the saturating drop counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated only with non-blocking assignments.
        if (rst) begin
            out_valid <= '0;
            // NOTE: the data registers are reset too, because out_data must read zero after reset.
            data_q    <= '0;
            drop_cnt  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (load[i]) begin
                    out_valid[i] <= 1'b1;
                    data_q[i]    <= in_data;
                end else if (out_valid[i] && out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule
